fib_iter: RTL

Iterative Fibonacci responder on the board-level four-phase req/ack handshake. It samples a request index `n`, computes F(n) with one add per clock, and presents `result` with `ack`. It holds `ack` until the requester drops `req`. It sits directly under the board top, which drives `req` from debounced keys and `n` from switches, and shows `result` on seven-segment displays.

---
 rtl/fib_iter_if.sv | 20 ++
 rtl/fib_iter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fib_iter_if.sv
// Four-phase req/ack bus between the board top (master) and fib_iter (slave).
// The ovf signal exists only when FIB_ITER_OVF_EN is defined.
interface fib_iter_if #(
    parameter int unsigned N_IN  = 10,
    parameter int unsigned N_OUT = 24
);
    logic             req;
    logic [N_IN-1:0]  n;
    logic             ack;
    logic [N_OUT-1:0] result;
`ifdef FIB_ITER_OVF_EN
    logic             ovf;

    modport master (output req, output n, input ack, input result, input ovf);
    modport slave  (input req, input n, output ack, output result, output ovf);
`else
    modport master (output req, output n, input ack, input result);
    modport slave  (input req, input n, output ack, output result);
`endif
endinterface

// File: rtl/fib_iter.sv
// Iterative Fibonacci responder: one add per clock, result held with ack until req drops.
// Optional sticky overflow flag on the bus when FIB_ITER_OVF_EN is defined.
module fib_iter #(
    parameter int unsigned N_IN  = 10,
    parameter int unsigned N_OUT = 24
) (
    input  logic       clk,
    input  logic       RSTN,
    fib_iter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [N_IN-1:0]  CNT_ONE = 1;
    localparam logic [N_OUT-1:0] VAL_ONE = 1;

    state_t           state_q, state_d;
    logic [N_OUT-1:0] a_q, a_d;
    logic [N_OUT-1:0] b_q, b_d;
    logic [N_IN-1:0]  cnt_q, cnt_d;
    logic [N_OUT-1:0] result_q, result_d;
    logic             ack_q, ack_d;
    logic [N_OUT:0]   sum;
`ifdef FIB_ITER_OVF_EN
    logic             ob_q, ob_d;
    logic             oa_q, oa_d;
    logic             ovf_q, ovf_d;
`endif

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ack_d    = ack_q;
`ifdef FIB_ITER_OVF_EN
        ob_d     = ob_q;
        oa_d     = oa_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    cnt_d   = bus.n;
                    a_d     = '0;
                    b_d     = VAL_ONE;
`ifdef FIB_ITER_OVF_EN
                    ob_d    = 1'b0;
                    oa_d    = 1'b0;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    result_d = a_q;
                    ack_d    = 1'b1;
`ifdef FIB_ITER_OVF_EN
                    ovf_d    = oa_q;
`endif
                    state_d  = DONE;
                end else begin
                    a_d   = b_q;
                    b_d   = sum[N_OUT-1:0];
                    cnt_d = cnt_q - CNT_ONE;
`ifdef FIB_ITER_OVF_EN
                    // a inherits b's flag; a wrap in b alone stays in ob until it shifts into a
                    oa_d  = ob_q;
                    ob_d  = ob_q | sum[N_OUT];
`endif
                end
            end
            DONE: begin
                if (!bus.req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ack_q    <= 1'b0;
`ifdef FIB_ITER_OVF_EN
            ob_q     <= 1'b0;
            oa_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ack_q    <= ack_d;
`ifdef FIB_ITER_OVF_EN
            ob_q     <= ob_d;
            oa_q     <= oa_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.ack    = ack_q;
    assign bus.result = result_q;
`ifdef FIB_ITER_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule
